// File: rtl/tone_channel_scheduler_if.sv
// Request/response bundle between the music and sfx sources and the
// single-voice tone channel scheduler.
interface tone_channel_scheduler_if;
  logic [7:0] music_note;
  logic [3:0] music_dur;
  logic       music_valid;
  logic       music_ready;
  logic       sfx_req;
  logic [7:0] sfx_note;
  logic [3:0] sfx_dur;
  logic       sfx_ack;
  logic [7:0] note_out;
  logic       sfx_active;
  logic       tick_out;

  modport master (
    output music_note, music_dur, music_valid, sfx_req, sfx_note, sfx_dur,
    input  music_ready, sfx_ack, note_out, sfx_active, tick_out
  );
  modport slave (
    input  music_note, music_dur, music_valid, sfx_req, sfx_note, sfx_dur,
    output music_ready, sfx_ack, note_out, sfx_active, tick_out
  );
endinterface

// File: rtl/tone_channel_scheduler.sv
// Shares one tone generator between a music step source and a preempting
// sound-effect port; interrupted music is saved and resumed after the sfx.
module tone_channel_scheduler #(
  parameter int TICK_BITS = 18,
  parameter int GAP_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  tone_channel_scheduler_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUSIC, S_SFX, S_GAP} state_t;

  localparam logic [3:0] GAP_LOAD = (GAP_TICKS == 0) ? 4'd0 : 4'(GAP_TICKS - 1);
  localparam state_t     S_DONE   = (GAP_TICKS == 0) ? S_IDLE : S_GAP;

  state_t               r_state, w_state_nxt;
  logic [TICK_BITS-1:0] r_cnt;
  logic [3:0]           r_remain, w_remain_nxt, r_gap, w_gap_nxt;
  logic [3:0]           r_sv_remain, w_sv_remain_nxt;
  logic [7:0]           r_cur, w_cur_nxt, r_sv_note, w_sv_note_nxt, r_note_out;
  logic                 r_saved, w_saved_nxt, r_ack, r_tick;
  logic                 w_tick, w_expire, w_take_sfx, w_take_music;

  assign w_tick          = en & (&r_cnt);
  assign w_expire        = w_tick & (r_remain == 4'd0);
  assign w_take_sfx      = en & bus.sfx_req & (r_state != S_SFX);
  assign bus.music_ready = en & (r_state == S_IDLE) & ~bus.sfx_req;
  assign w_take_music    = bus.music_valid & bus.music_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_remain_nxt    = r_remain;
    w_gap_nxt       = r_gap;
    w_cur_nxt       = r_cur;
    w_saved_nxt     = r_saved;
    w_sv_note_nxt   = r_sv_note;
    w_sv_remain_nxt = r_sv_remain;
    if (en) begin
      unique case (r_state)
        S_IDLE: if (w_take_music) begin
          w_state_nxt  = S_MUSIC;
          w_cur_nxt    = bus.music_note;
          w_remain_nxt = bus.music_dur;
        end
        S_MUSIC: begin
          if (w_take_sfx && !w_expire) begin
            // a tick landing on the preempting edge still counts against the music note
            w_saved_nxt     = 1'b1;
            w_sv_note_nxt   = r_cur;
            w_sv_remain_nxt = w_tick ? r_remain - 4'd1 : r_remain;
          end else if (w_expire) begin
            w_state_nxt = S_DONE;
            w_gap_nxt   = GAP_LOAD;
          end else if (w_tick) begin
            w_remain_nxt = r_remain - 4'd1;
          end
        end
        S_SFX: begin
          if (w_expire) begin
            if (r_saved) begin
              w_state_nxt  = S_MUSIC;
              w_cur_nxt    = r_sv_note;
              w_remain_nxt = r_sv_remain;
              w_saved_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_DONE;
              w_gap_nxt   = GAP_LOAD;
            end
          end else if (w_tick) begin
            w_remain_nxt = r_remain - 4'd1;
          end
        end
        S_GAP: if (w_tick) begin
          if (r_gap == 4'd0) w_state_nxt = S_IDLE;
          else               w_gap_nxt   = r_gap - 4'd1;
        end
      endcase
      // sfx acceptance overrides whatever the current state decided
      if (w_take_sfx) begin
        w_state_nxt  = S_SFX;
        w_cur_nxt    = bus.sfx_note;
        w_remain_nxt = bus.sfx_dur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_remain    <= '0;
      r_gap       <= '0;
      r_cur       <= '0;
      r_saved     <= 1'b0;
      r_sv_note   <= '0;
      r_sv_remain <= '0;
      r_note_out  <= '0;
      r_ack       <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      if (en) r_cnt <= r_cnt + TICK_BITS'(1);
      r_state     <= w_state_nxt;
      r_remain    <= w_remain_nxt;
      r_gap       <= w_gap_nxt;
      r_cur       <= w_cur_nxt;
      r_saved     <= w_saved_nxt;
      r_sv_note   <= w_sv_note_nxt;
      r_sv_remain <= w_sv_remain_nxt;
      r_ack       <= w_take_sfx;
      r_tick      <= w_tick;
      r_note_out  <= (en && (w_state_nxt == S_MUSIC || w_state_nxt == S_SFX)) ? w_cur_nxt : 8'd0;
    end
  end

  assign bus.note_out   = r_note_out;
  assign bus.sfx_ack    = r_ack;
  assign bus.tick_out   = r_tick;
  assign bus.sfx_active = (r_state == S_SFX);
endmodule

// File: tb/tb_tone_channel_scheduler.sv
// Bench for tone_channel_scheduler: directed vector table, hand-written
// preemption/enable/reset sequences, and random traffic against a note-level model.
module tb_tone_channel_scheduler;
  localparam int TB  = 4;
  localparam int GT  = 1;
  localparam int PER = 1 << TB;
  localparam int M_IDLE = 0, M_MUSIC = 1, M_SFX = 2, M_GAP = 3;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  tone_channel_scheduler_if bus();

  tone_channel_scheduler #(.TICK_BITS(TB), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model: a note is a (code, ticks still to play) pair; preempted music waits in a queue.
  typedef struct { logic [7:0] note; int left; } held_t;
  held_t      saved_q[$];
  int         m_mode = M_IDLE, m_encyc = 0, m_left = 0, m_gapleft = 0;
  logic [7:0] m_note = '0;
  logic [7:0] e_note = '0;
  logic       e_ack = 1'b0, e_act = 1'b0, e_tick = 1'b0;

  typedef struct {
    logic rst_n, en, mv; logic [7:0] mn; logic [3:0] md;
    logic sr; logic [7:0] sn; logic [3:0] sd; int n;
    logic [7:0] x_note; logic x_ack, x_act, x_rdy;
  } vec_t;
  vec_t tbl[11];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_start(logic [7:0] n, logic [3:0] d, int mode);
    m_mode = mode; m_note = n; m_left = int'(d) + 1;
  endtask

  task automatic m_finish();
    if (GT > 0) begin m_mode = M_GAP; m_gapleft = GT; end
    else m_mode = M_IDLE;
  endtask

  task automatic model_step();
    logic  tick, take;
    held_t h;
    e_ack = 1'b0; e_tick = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_encyc = 0; saved_q.delete(); e_note = '0; e_act = 1'b0;
      return;
    end
    if (!en) begin
      e_note = '0; e_act = (m_mode == M_SFX);
      return;
    end
    tick = ((m_encyc % PER) == PER - 1);
    m_encyc++;
    take = bus.sfx_req && (m_mode != M_SFX);
    case (m_mode)
      M_IDLE: if (!take && bus.music_valid) m_start(bus.music_note, bus.music_dur, M_MUSIC);
      M_MUSIC: begin
        if (take) begin
          if (!(tick && m_left == 1)) begin
            h.note = m_note; h.left = m_left - (tick ? 1 : 0);
            saved_q.push_back(h);
          end
        end else if (tick) begin
          if (m_left == 1) m_finish(); else m_left--;
        end
      end
      M_SFX: if (tick) begin
        if (m_left == 1) begin
          if (saved_q.size() > 0) begin
            h = saved_q.pop_front();
            m_mode = M_MUSIC; m_note = h.note; m_left = h.left;
          end else m_finish();
        end else m_left--;
      end
      default: if (!take && tick) begin
        if (m_gapleft == 1) m_mode = M_IDLE; else m_gapleft--;
      end
    endcase
    if (take) begin m_start(bus.sfx_note, bus.sfx_dur, M_SFX); e_ack = 1'b1; end
    e_tick = tick;
    e_note = (m_mode == M_MUSIC || m_mode == M_SFX) ? m_note : 8'd0;
    e_act  = (m_mode == M_SFX);
  endtask

  task automatic cyc();
    #1;
    if (rst_n)
      check("music_ready", 32'(bus.music_ready),
            32'(en && m_mode == M_IDLE && !bus.sfx_req));
    model_step();
    @(posedge clk); #1;
    check("note/ack/act/tick",
          32'({bus.note_out, bus.sfx_ack, bus.sfx_active, bus.tick_out}),
          32'({e_note, e_ack, e_act, e_tick}));
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic quiet();
    bus.music_valid = 1'b0; bus.music_note = '0; bus.music_dur = '0;
    bus.sfx_req = 1'b0; bus.sfx_note = '0; bus.sfx_dur = '0;
  endtask

  task automatic do_reset();
    quiet(); en = 1'b1; rst_n = 1'b0; run(2); rst_n = 1'b1;
  endtask

  task automatic music(logic [7:0] n, logic [3:0] d);
    bus.music_valid = 1'b1; bus.music_note = n; bus.music_dur = d; run(1);
    bus.music_valid = 1'b0;
  endtask

  initial begin
    int acks, ticks, loud;
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 3,  8'h00, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h15, 4'h2, 1'b0, 8'h00, 4'h0, 1,  8'h15, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 14, 8'h15, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1,  8'h15, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 32, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 16, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h44, 4'h0, 1'b1, 8'h30, 4'h0, 1,  8'h30, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h44, 4'h0, 1'b0, 8'h30, 4'h0, 1,  8'h30, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h44, 4'h0, 1'b0, 8'h30, 4'h0, 14, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h44, 4'h0, 1'b0, 8'h30, 4'h0, 16, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h44, 4'h0, 1'b0, 8'h30, 4'h0, 1,  8'h44, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en;
      bus.music_valid = tbl[i].mv; bus.music_note = tbl[i].mn; bus.music_dur = tbl[i].md;
      bus.sfx_req = tbl[i].sr; bus.sfx_note = tbl[i].sn; bus.sfx_dur = tbl[i].sd;
      run(tbl[i].n);
      check($sformatf("tbl%0d note", i),  32'(bus.note_out),    32'(tbl[i].x_note));
      check($sformatf("tbl%0d ack", i),   32'(bus.sfx_ack),     32'(tbl[i].x_ack));
      check($sformatf("tbl%0d act", i),   32'(bus.sfx_active),  32'(tbl[i].x_act));
      check($sformatf("tbl%0d ready", i), 32'(bus.music_ready), 32'(tbl[i].x_rdy));
    end

    // sfx preempts a music note with 3 ticks elapsed, then the music resumes
    do_reset();
    music(8'h15, 4'd5); run(48);
    bus.sfx_req = 1'b1; bus.sfx_note = 8'h2A; bus.sfx_dur = 4'd1; run(1);
    bus.sfx_req = 1'b0;
    check("preempt sfx note", 32'(bus.note_out), 32'h2A);
    run(29); check("sfx still playing", 32'(bus.note_out), 32'h2A);
    run(2);  check("music resumed", 32'(bus.note_out), 32'h15);
    run(46); check("resumed music last", 32'(bus.note_out), 32'h15);
    run(2);  check("resumed music ended", 32'(bus.note_out), 32'h00);

    // sfx_req held through an sfx: one ack per acceptance, music resumes
    do_reset();
    music(8'h15, 4'd2); run(1);
    bus.sfx_req = 1'b1; bus.sfx_note = 8'h2A; bus.sfx_dur = 4'd0;
    acks = 0;
    repeat (28) begin cyc(); if (bus.sfx_ack) acks++; end
    bus.sfx_req = 1'b0;
    check("held req ack count", 32'(acks), 32'd2);
    run(2);  check("music after repeated sfx", 32'(bus.note_out), 32'h15);
    run(48); check("music after repeated sfx done", 32'(bus.note_out), 32'h00);

    // en low for 40 cycles mid-note freezes timing and mutes
    do_reset();
    music(8'h21, 4'd3); run(20);
    en = 1'b0; ticks = 0;
    repeat (40) begin cyc(); if (bus.tick_out) ticks++; end
    check("muted while disabled", 32'(bus.note_out), 32'h00);
    check("no ticks while disabled", 32'(ticks), 32'd0);
    en = 1'b1;
    run(1);  check("note restored", 32'(bus.note_out), 32'h21);
    run(41); check("note held after resume", 32'(bus.note_out), 32'h21);
    run(1);  check("note ends on schedule", 32'(bus.note_out), 32'h00);

    // reset during sfx with saved music abandons both
    do_reset();
    music(8'h15, 4'd5); run(3);
    bus.sfx_req = 1'b1; bus.sfx_note = 8'h2A; bus.sfx_dur = 4'd3; run(1);
    bus.sfx_req = 1'b0; run(5);
    check("sfx before reset", 32'(bus.sfx_active), 32'd1);
    rst_n = 1'b0; run(1); rst_n = 1'b1;
    check("reset note", 32'(bus.note_out), 32'h00);
    check("reset active", 32'(bus.sfx_active), 32'd0);
    check("reset ready", 32'(bus.music_ready), 32'd1);
    loud = 0;
    repeat (150) begin cyc(); if (bus.note_out != 8'h00) loud++; end
    check("no resume after reset", 32'(loud), 32'd0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en = ($urandom_range(0, 19) != 0);
      bus.music_valid = $urandom_range(0, 1) == 1;
      bus.music_note = 8'($urandom); bus.music_dur = 4'($urandom_range(0, 3));
      bus.sfx_req = ($urandom_range(0, 11) == 0);
      bus.sfx_note = 8'($urandom); bus.sfx_dur = 4'($urandom_range(0, 3));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tone_channel_scheduler.md
Name: tone_channel_scheduler

Overview:
- Sequences the single-voice tone generator and shares it between two requesters: a background music step source and a sound-effect (sfx) request port.
- Produces the 8-bit note code the tone generator consumes; note code 0 means silence.
- Timing is driven by a tempo tick derived from clk. Sfx preempts music; the interrupted music note is saved and resumed afterwards.
- Sits between the music ROM/sequencer logic and the tone generator in the audio path.

Parameters:
- TICK_BITS, 18: width of the free-running tempo counter. One tick occurs every 2^TICK_BITS enabled cycles.
- GAP_TICKS, 1: silent ticks inserted after each completed note (0 = no gap).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  global enable; low freezes all timing and silences the output.
- music_note  in  8  next music note code.
- music_dur  in  4  next music duration; d plays d+1 ticks.
- music_valid  in  1  music step available.
- music_ready  out  1  scheduler accepts a music step this cycle (combinational).
- sfx_req  in  1  level request for a sound effect.
- sfx_note  in  8  sfx note code, sampled on acceptance.
- sfx_dur  in  4  sfx duration; d plays d+1 ticks.
- sfx_ack  out  1  one-cycle pulse: sfx accepted (registered).
- note_out  out  8  note code to the tone generator (registered).
- sfx_active  out  1  high while in state SFX.
- tick_out  out  1  tempo tick pulse (registered).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; note_out=0, sfx_ack=0, sfx_active=0, tick_out=0.
  - tick counter=0, remain=0, saved flag=0.
  - Reset mid-note abandons the note and any saved music with no ack.
- Tick:
  - The TICK_BITS counter increments each cycle when en=1.
  - tick=1 in the cycle the counter equals all-ones (it wraps to 0 next cycle).
  - tick_out is the registered copy of tick.
- en=0: the tick counter, state, remain, and saved registers hold. note_out is forced to 0 and sfx_ack=0. music_ready=0 and sfx_req is not accepted. Operation resumes unchanged when en returns to 1.
- States: IDLE, MUSIC, SFX, GAP. note_out=0 in IDLE and GAP.
- IDLE transitions:
  - If sfx_req: accept the sfx → SFX.
  - Else if music_valid: accept the music step → MUSIC.
  - music_ready = en & (state==IDLE) & ~sfx_req. Sfx always has priority.
- Music acceptance (music_valid & music_ready at an edge): next cycle state=MUSIC, note_out=music_note, remain=music_dur.
- Sfx acceptance: in the next cycle
  - state=SFX, note_out=sfx_note, remain=sfx_dur;
  - sfx_ack=1 for exactly that cycle; sfx_active=1.
- Sfx acceptance windows: IDLE, MUSIC or GAP with en=1 and sfx_req=1. sfx_req is ignored while in SFX; a level still high when SFX ends counts as a new request.
- MUSIC:
  - On tick with remain==0 → GAP (or IDLE if GAP_TICKS=0).
  - On tick with remain>0: remain decrements.
  - sfx_req with no coinciding expiry: save the current music note and remain, set saved=1, go to SFX.
  - sfx_req coinciding with expiry (tick & remain==0): the music note is complete, nothing is saved, go to SFX.
- SFX: on tick with remain==0:
  - if saved=1 → MUSIC, restoring note_out and remain; clear saved;
  - else → GAP (or IDLE if GAP_TICKS=0).
  - Otherwise decrement remain on tick.
- GAP: load gap count GAP_TICKS-1 on entry; decrement on tick; at tick with count==0 → IDLE. sfx_req preempts GAP (saved stays 0).
- Duration accounting: a note lasts from its load cycle until the (d+1)th tick after load. The first partial tick interval counts as a full tick, so elapsed time varies by up to one tick period.
- Width rules:
  - remain and gap count are 4 bits; GAP_TICKS is limited to 1..16 when nonzero.
  - Note codes pass through unmodified; code 0 is legal and plays silence for its duration.

Test Plan:
1. TICK_BITS=4, GAP_TICKS=1: reset, then music_valid with note 8'h15, dur 2 → music_ready=1 and note_out=8'h15 the next cycle. note_out returns to 0 after the 3rd tick. After 1 more tick music_ready=1 again.
2. In IDLE, drive sfx_req and music_valid in the same cycle (sfx_note 8'h30, dur 0) → music_ready=0, one-cycle sfx_ack, note_out=8'h30 for one tick, then GAP, then the music step is accepted.
3. During music note 8'h15 dur 5 with 3 ticks elapsed, raise sfx_req (note 8'h2A, dur 1) → note_out=8'h2A for 2 ticks, then 8'h15 resumes and ends after 3 more ticks.
4. sfx_req held high through an entire SFX → sfx_ack only at acceptance. The effect is re-accepted with a new ack only after SFX ends, and the music in progress is resumed after the second SFX only if it was saved.
5. Drop en for 40 cycles mid-MUSIC → note_out=0 and tick_out stays 0. On en=1 note_out restores the same note, and the remaining tick count is unchanged.
6. Assert rst_n=0 for one cycle during SFX with saved music → next cycle state IDLE, note_out=0, sfx_active=0, and no music resume afterwards.
